// File: rtl/ddr_rd_arb_pkg.sv
// Shared types and constants for the DDR burst-read arbiter.
package ddr_rd_arb_pkg;

  localparam int LEN_W      = 8;
  localparam int BEAT_CNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  // Width helper: bits needed to hold values 0..value-1, never below 1.
  function automatic int clog2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ddr_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after the pointer wins.
module rr_pick
  import ddr_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    // Scan ptr+1, ptr+2, ... so the last winner has the lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR burst-read port among NUM_REQ clients.
module ddr_rd_arbiter
  import ddr_rd_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = 30,
  parameter int MEM_DATA_BITS = 256,
  parameter int NUM_REQ       = 2,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic                          ddr_clk_i,
  input  logic                          ddr_rst_i,
  input  logic [NUM_REQ-1:0]            cli_req_i,
  input  logic [NUM_REQ*LEN_W-1:0]      cli_len_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] cli_addr_i,
  output logic [NUM_REQ-1:0]            cli_data_valid_o,
  output logic [MEM_DATA_BITS-1:0]      cli_data_o,
  output logic [NUM_REQ-1:0]            cli_finish_o,
  output logic                          rd_ddr_req_o,
  output logic [LEN_W-1:0]              rd_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]         rd_ddr_addr_o,
  input  logic                          rd_ddr_data_valid_i,
  input  logic [MEM_DATA_BITS-1:0]      rd_ddr_data_i,
  input  logic                          rd_ddr_finish_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          len_err_o,
  output logic                          timeout_o
);

  localparam int                    IDX_W    = clog2(NUM_REQ);
  localparam int                    WD_W     = clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]       WD_MAX   = WD_W'(TIMEOUT_CYC);
  localparam logic [BEAT_CNT_W-1:0] BEAT_MAX = '1;
  localparam logic [IDX_W-1:0]      PTR_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      req_q, req_d;
  logic [BEAT_CNT_W-1:0]     beat_q, beat_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      timeout_q, timeout_d;
  logic                      len_err_q, len_err_d;

  logic [NUM_REQ-1:0]        pick_onehot;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_any;
  logic                      in_busy;
  logic                      beat_ok;
  logic                      fin_ok;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i (cli_req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_onehot),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_BUSY;
      ST_BUSY:  if (rd_ddr_finish_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Return path is steered by the registered grant; traffic outside BUSY is dropped.
  always_comb begin
    in_busy          = (state_q == ST_BUSY);
    beat_ok          = rd_ddr_data_valid_i & in_busy;
    fin_ok           = rd_ddr_finish_i & in_busy;
    cli_data_valid_o = grant_q & {NUM_REQ{beat_ok}};
    cli_finish_o     = grant_q & {NUM_REQ{fin_ok}};
    cli_data_o       = rd_ddr_data_i;
  end

  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    len_d     = len_q;
    addr_d    = addr_q;
    req_d     = req_q;
    beat_d    = beat_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    len_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_onehot;
          ptr_d   = pick_idx;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_onehot[k]) begin
              len_d  = cli_len_i[k*LEN_W +: LEN_W];
              addr_d = cli_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
          end
        end
      end
      ST_ISSUE: begin
        req_d  = 1'b1;
        beat_d = '0;
        wd_d   = '0;
      end
      ST_BUSY: begin
        if (beat_ok && (beat_q != BEAT_MAX)) beat_d = beat_q + 1'b1;
        if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
        if (wd_d == WD_MAX) timeout_d = 1'b1;
        // beat_d already includes a beat that lands together with finish.
        if (fin_ok) begin
          req_d     = 1'b0;
          grant_d   = '0;
          len_err_d = (beat_d != BEAT_CNT_W'(len_q));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      ptr_q     <= PTR_RST;
      grant_q   <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      req_q     <= 1'b0;
      beat_q    <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      beat_q    <= beat_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      len_err_q <= len_err_d;
    end
  end

  assign rd_ddr_req_o  = req_q;
  assign rd_ddr_len_o  = len_q;
  assign rd_ddr_addr_o = addr_q;
  assign grant_o       = grant_q;
  assign len_err_o     = len_err_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Scoreboard bench for ddr_rd_arbiter: RR model predicts grants, DDR model returns beats.
`timescale 1ns/1ps
module tb_ddr_rd_arbiter;

  localparam int AW   = 30;
  localparam int DW   = 256;
  localparam int NREQ = 2;
  localparam int TMO  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    cli_req;
  logic [NREQ*8-1:0]  cli_len;
  logic [NREQ*AW-1:0] cli_addr;
  logic [NREQ-1:0]    cli_data_valid, cli_finish, grant;
  logic [DW-1:0]      cli_data, rd_data;
  logic               rd_req, rd_valid, rd_finish, len_err, timeout;
  logic [7:0]         rd_len;
  logic [AW-1:0]      rd_addr;

  logic               c_req  [NREQ];
  logic [7:0]         c_len  [NREQ];
  logic [AW-1:0]      c_addr [NREQ];
  logic               rv_m = 1'b0, rf_m = 1'b0, rv_s = 1'b0, rf_s = 1'b0;
  logic [DW-1:0]      rd_data_m = '0;

  always_comb begin
    cli_req  = '0;
    cli_len  = '0;
    cli_addr = '0;
    for (int k = 0; k < NREQ; k++) begin
      cli_req[k]            = c_req[k];
      cli_len[k*8 +: 8]     = c_len[k];
      cli_addr[k*AW +: AW]  = c_addr[k];
    end
  end
  assign rd_valid  = rv_m | rv_s;
  assign rd_finish = rf_m | rf_s;
  assign rd_data   = rd_data_m;

  ddr_rd_arbiter #(
    .ADDR_WIDTH(AW), .MEM_DATA_BITS(DW), .NUM_REQ(NREQ), .TIMEOUT_CYC(TMO)
  ) dut (
    .ddr_clk_i(clk), .ddr_rst_i(rst),
    .cli_req_i(cli_req), .cli_len_i(cli_len), .cli_addr_i(cli_addr),
    .cli_data_valid_o(cli_data_valid), .cli_data_o(cli_data), .cli_finish_o(cli_finish),
    .rd_ddr_req_o(rd_req), .rd_ddr_len_o(rd_len), .rd_ddr_addr_o(rd_addr),
    .rd_ddr_data_valid_i(rd_valid), .rd_ddr_data_i(rd_data), .rd_ddr_finish_i(rd_finish),
    .grant_o(grant), .len_err_o(len_err), .timeout_o(timeout)
  );

  typedef struct {
    int          client;
    logic [7:0]  len;
    logic [AW-1:0] addr;
    int          nbeats;
    bit          fin_last;
    int          fin_delay;
    bit          no_fin;
  } burst_t;
  typedef struct { int client; logic [DW-1:0] data; } beat_t;
  typedef struct { int client; bit lerr; } fin_t;

  burst_t exp_grant[$];
  burst_t resp_q[$];
  beat_t  exp_beat[$];
  fin_t   exp_fin[$];

  int checks = 0;
  int errors = 0;
  int model_last = NREQ - 1;
  int beat_seen = 0;
  logic [7:0]    plan_len  [NREQ][8];
  logic [AW-1:0] plan_addr [NREQ][8];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: records the burst the arbiter must issue next and what it returns.
  task automatic push_burst(input int c, input logic [7:0] len, input logic [AW-1:0] addr,
                            input int nb, input bit fl, input int fd, input bit nf);
    burst_t b;
    fin_t   f;
    b.client = c; b.len = len; b.addr = addr; b.nbeats = nb;
    b.fin_last = fl; b.fin_delay = fd; b.no_fin = nf;
    exp_grant.push_back(b);
    resp_q.push_back(b);
    if (!nf) begin
      f.client = c;
      f.lerr   = (nb != int'(len));
      exp_fin.push_back(f);
    end
    model_last = c;
  endtask

  task automatic gen_plan(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      plan_len[k][i]  = 8'(1 + $urandom % 24);
      plan_addr[k][i] = AW'($urandom);
    end
  endtask

  // All listed clients request together and hold: order follows plain round robin.
  task automatic predict(input int n0, input int n1);
    int rem [NREQ];
    int idx [NREQ];
    int c;
    rem[0] = n0; rem[1] = n1; idx[0] = 0; idx[1] = 0;
    while (rem[0] + rem[1] > 0) begin
      c = -1;
      for (int j = 1; j <= NREQ; j++)
        if (c < 0 && rem[(model_last + j) % NREQ] > 0) c = (model_last + j) % NREQ;
      push_burst(c, plan_len[c][idx[c]], plan_addr[c][idx[c]], int'(plan_len[c][idx[c]]),
                 1'($urandom % 2), 1 + int'($urandom % 3), 1'b0);
      idx[c]++;
      rem[c]--;
    end
  endtask

  task automatic client_run(input int k, input int nb);
    int n;
    for (int b = 0; b < nb; b++) begin
      c_len[k]  = plan_len[k][b];
      c_addr[k] = plan_addr[k][b];
      c_req[k]  = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!cli_finish[k] && n < 3000);
      chk($sformatf("client%0d_finish_wait", k), DW'(n < 3000), DW'(1));
      @(posedge clk); #1;
      c_req[k] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic serve(input burst_t d);
    int n;
    for (int b = 0; b < d.nbeats; b++) begin
      int gap;
      gap = int'($urandom % 2);
      repeat (gap) begin
        @(posedge clk); #1;
        rv_m = 1'b0; rf_m = 1'b0;
      end
      @(posedge clk); #1;
      rd_data_m = rand_data();
      rv_m = 1'b1;
      rf_m = d.fin_last && !d.no_fin && (b == d.nbeats - 1);
      exp_beat.push_back('{client: d.client, data: rd_data_m});
    end
    @(posedge clk); #1;
    rv_m = 1'b0; rf_m = 1'b0;
    if (d.no_fin) begin
      n = 0;
      while (!rst && n < 3000) begin @(negedge clk); n++; end
    end else if (!(d.fin_last && d.nbeats > 0)) begin
      repeat (d.fin_delay - 1) begin @(posedge clk); #1; end
      rf_m = 1'b1;
      @(posedge clk); #1;
      rf_m = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (rd_req && n < 10);
    chk("ddr_req_drop", DW'(rd_req), DW'(0));
  endtask

  // DDR controller model.
  initial begin : ddr_model
    burst_t d;
    forever begin
      @(negedge clk);
      if (!rst && rd_req) begin
        if (resp_q.size() == 0) begin
          chk("ddr_req_unexpected", DW'(rd_req), DW'(0));
          while (rd_req) @(negedge clk);
        end else begin
          d = resp_q.pop_front();
          serve(d);
        end
      end
    end
  end

  // Monitor: compares every grant, beat and finish against the scoreboard.
  initial begin : monitor
    logic  req_prev;
    bit    lerr_pend, lerr_exp;
    burst_t g;
    beat_t  e;
    fin_t   f;
    req_prev = 1'b0; lerr_pend = 1'b0; lerr_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0;
        lerr_pend = 1'b0;
      end else begin
        if (rd_req && !req_prev) begin
          if (exp_grant.size() == 0) chk("grant_unexpected", DW'(grant), DW'(0));
          else begin
            g = exp_grant.pop_front();
            chk("grant_onehot", DW'(grant), DW'(1) << g.client);
            chk("rd_ddr_len", DW'(rd_len), DW'(g.len));
            chk("rd_ddr_addr", DW'(rd_addr), DW'(g.addr));
          end
        end
        req_prev = rd_req;
        if (lerr_pend || len_err) chk("len_err", DW'(len_err), DW'(lerr_pend && lerr_exp));
        lerr_pend = 1'b0;
        if (|cli_data_valid) begin
          if (exp_beat.size() == 0) chk("beat_unexpected", DW'(cli_data_valid), DW'(0));
          else begin
            e = exp_beat.pop_front();
            chk("beat_valid_vec", DW'(cli_data_valid), DW'(1) << e.client);
            chk("beat_data", cli_data, e.data);
            beat_seen++;
          end
        end
        if (|cli_finish) begin
          if (exp_fin.size() == 0) chk("finish_unexpected", DW'(cli_finish), DW'(0));
          else begin
            f = exp_fin.pop_front();
            chk("finish_vec", DW'(cli_finish), DW'(1) << f.client);
            lerr_pend = 1'b1;
            lerr_exp  = f.lerr;
          end
        end
      end
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n, base, mask, n0, n1;
    for (int k = 0; k < NREQ; k++) begin c_req[k] = 1'b0; c_len[k] = '0; c_addr[k] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", DW'(grant), DW'(0));
    chk("rst_req", DW'(rd_req), DW'(0));
    chk("rst_len_addr", DW'({rd_len, rd_addr}), DW'(0));
    chk("rst_flags", DW'({len_err, timeout, cli_data_valid, cli_finish}), DW'(0));

    // Traffic while idle must not reach any client.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rv_s = 1'b1; rf_s = 1'b1;
      @(negedge clk);
      chk("idle_valid_drop", DW'(cli_data_valid), DW'(0));
      chk("idle_finish_drop", DW'(cli_finish), DW'(0));
    end
    @(posedge clk); #1;
    rv_s = 1'b0; rf_s = 1'b0;
    @(posedge clk); #1;

    // Single client 0, latency and latch checks.
    push_burst(0, 8'd16, AW'(32'h1000), 16, 1'b0, 2, 1'b0);
    c_len[0] = 8'd16; c_addr[0] = AW'(32'h1000); c_req[0] = 1'b1;
    @(negedge clk);
    chk("lat_grant_c0", DW'(grant), DW'(0));
    @(negedge clk);
    chk("lat_grant_c1", DW'(grant), DW'(1));
    chk("lat_req_c1", DW'(rd_req), DW'(0));
    @(negedge clk);
    chk("lat_req_c2", DW'(rd_req), DW'(1));
    c_addr[0] = AW'(32'h3FFF_FFFF); c_len[0] = 8'h55;
    @(negedge clk);
    chk("latched_addr", DW'(rd_addr), DW'(32'h1000));
    chk("latched_len", DW'(rd_len), DW'(16));
    n = 0;
    do begin @(negedge clk); n++; end while (!cli_finish[0] && n < 3000);
    chk("t1_finish_wait", DW'(n < 3000), DW'(1));
    @(posedge clk); #1;
    c_req[0] = 1'b0;
    @(posedge clk); #1;

    // Both clients, four bursts each.
    gen_plan(0, 4); gen_plan(1, 4);
    predict(4, 4);
    fork
      client_run(0, 4);
      client_run(1, 4);
    join

    // Short burst: 7 beats for len 8.
    plan_len[0][0] = 8'd8; plan_addr[0][0] = AW'($urandom);
    push_burst(0, 8'd8, plan_addr[0][0], 7, 1'b0, 2, 1'b0);
    client_run(0, 1);

    // Last beat coincides with finish.
    plan_len[1][0] = 8'd4; plan_addr[1][0] = AW'($urandom);
    push_burst(1, 8'd4, plan_addr[1][0], 4, 1'b1, 1, 1'b0);
    client_run(1, 1);

    for (int r = 0; r < 3; r++) begin
      mask = 1 + int'($urandom % 3);
      n0 = mask[0] ? 1 + int'($urandom % 2) : 0;
      n1 = mask[1] ? 1 + int'($urandom % 2) : 0;
      gen_plan(0, n0); gen_plan(1, n1);
      predict(n0, n1);
      fork
        client_run(0, n0);
        client_run(1, n1);
      join
    end

    // Watchdog: finish held back well past TMO busy cycles.
    plan_len[0][0] = 8'd8; plan_addr[0][0] = AW'($urandom);
    push_burst(0, 8'd8, plan_addr[0][0], 8, 1'b0, 90, 1'b0);
    fork
      client_run(0, 1);
      begin
        n = 0;
        while (!rd_req && n < 200) begin @(negedge clk); n++; end
        chk("tmo_req_seen", DW'(n < 200), DW'(1));
        repeat (59) @(negedge clk);
        chk("tmo_low_at_60", DW'(timeout), DW'(0));
        repeat (10) @(negedge clk);
        chk("tmo_high_at_70", DW'(timeout), DW'(1));
      end
    join
    chk("tmo_sticky", DW'(timeout), DW'(1));

    // Reset in the middle of a burst, then pointer restart.
    push_burst(0, 8'd16, AW'($urandom), 5, 1'b0, 1, 1'b1);
    c_len[0] = 8'd16; c_addr[0] = exp_grant[exp_grant.size()-1].addr; c_req[0] = 1'b1;
    base = beat_seen;
    n = 0;
    while (beat_seen < base + 5 && n < 500) begin @(negedge clk); n++; end
    chk("rst_mid_beats", DW'(beat_seen - base), DW'(5));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; c_req[0] = 1'b0; model_last = NREQ - 1;
    @(negedge clk);
    chk("rst_mid_req", DW'(rd_req), DW'(0));
    chk("rst_mid_grant", DW'(grant), DW'(0));
    chk("rst_mid_timeout", DW'(timeout), DW'(0));
    @(posedge clk); #1;
    gen_plan(0, 1); gen_plan(1, 1);
    predict(1, 1);
    fork
      client_run(0, 1);
      client_run(1, 1);
    join

    repeat (5) @(negedge clk);
    chk("left_grants", DW'(exp_grant.size()), DW'(0));
    chk("left_beats", DW'(exp_beat.size()), DW'(0));
    chk("left_finishes", DW'(exp_fin.size()), DW'(0));
    chk("left_resp", DW'(resp_q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
